// File: rtl/icache_pkg.sv
// Shared constants and enums for the L1I port scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_pkg;

  localparam int OFFSET_SIZE    = 5;
  localparam int INDEX_SIZE     = 8;
  localparam int TAG_SIZE       = 64 - (OFFSET_SIZE + INDEX_SIZE);
  localparam int LINE_BITS      = (2 ** OFFSET_SIZE) * 8;
  localparam int FILL_BURST_DEF = 4;

  // What the memory port is being driven with in the current cycle.
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  // Arbitration outcome for the cycle; takes effect at the memory next cycle.
  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_READ,
    DEC_WRITE
  } dec_t;

endpackage

// File: rtl/icache_fill_buffer.sv
// One-entry holding buffer for cacheline fills awaiting a write slot.
// Latency: loads at the accepting edge, visible the following cycle.
// Backpressure: ready is registered and equals "empty"; drains on the write-issue edge.
// Ports: clk/rst; fill_valid + fill_* payload in; drain (write issued) in;
//        ready, buf_valid and buffered payload out.
module icache_fill_buffer
  import icache_pkg::*;
#(
  parameter int OFFSET_W = OFFSET_SIZE,
  parameter int INDEX_W  = INDEX_SIZE,
  parameter int TAG_W    = TAG_SIZE,
  parameter int LINE_W   = LINE_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fill_valid,
  input  logic [LINE_W-1:0]   fill_line,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [OFFSET_W-1:0] fill_offset,
  input  logic                drain,
  output logic                ready,
  output logic                buf_valid,
  output logic [LINE_W-1:0]   buf_line,
  output logic [TAG_W-1:0]    buf_tag,
  output logic [INDEX_W-1:0]  buf_index,
  output logic [OFFSET_W-1:0] buf_offset
);

  // Load and drain are mutually exclusive: load needs an empty buffer,
  // drain is only issued while it is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      ready      <= 1'b1;
      buf_line   <= '0;
      buf_tag    <= '0;
      buf_index  <= '0;
      buf_offset <= '0;
    end else if (fill_valid && ready) begin
      buf_valid  <= 1'b1;
      ready      <= 1'b0;
      buf_line   <= fill_line;
      buf_tag    <= fill_tag;
      buf_index  <= fill_index;
      buf_offset <= fill_offset;
    end else if (drain) begin
      buf_valid  <= 1'b0;
      ready      <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_port_scheduler.sv
// Shares the single L1I memory port between fetch lookups and line fills.
// Latency: decision in cycle t drives the memory in t+1; fills issue >= 2 cycles after accept.
// Backpressure: fetchReady_o is a combinational grant; fillReady_o is registered buffer-empty.
// Ports: clock_i/reset_i; fetch request (valid/tag/index/offset, ready);
//        fill request (valid/cacheline/tag/index/offset, ready); registered mem* port.
// Optional: ICACHE_SCHED_STATS_EN adds statFetchGrants_o/statFillGrants_o/statBubbles_o.
module icache_port_scheduler
  import icache_pkg::*;
#(
  parameter int offsetSize          = OFFSET_SIZE,
  parameter int indexSize           = INDEX_SIZE,
  parameter int tagSize             = 64 - (offsetSize + indexSize),
  parameter int cachelineSizeInBits = (2 ** offsetSize) * 8,
  parameter int FILL_BURST_MAX      = FILL_BURST_DEF
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           fetchValid_i,
  input  logic [tagSize-1:0]             fetchTag_i,
  input  logic [indexSize-1:0]           fetchIndex_i,
  input  logic [offsetSize-1:0]          fetchOffset_i,
  output logic                           fetchReady_o,
  input  logic                           fillValid_i,
  input  logic [cachelineSizeInBits-1:0] fillCacheline_i,
  input  logic [tagSize-1:0]             fillTag_i,
  input  logic [indexSize-1:0]           fillIndex_i,
  input  logic [offsetSize-1:0]          fillOffset_i,
  output logic                           fillReady_o,
  output logic                           memFetchEnable_o,
  output logic [tagSize-1:0]             memTag_o,
  output logic [indexSize-1:0]           memIndex_o,
  output logic [offsetSize-1:0]          memOffset_o,
  output logic                           memUpdateEnable_o,
  output logic [cachelineSizeInBits-1:0] memNewCacheline_o,
  output logic [tagSize-1:0]             memNewTag_o,
  output logic [indexSize-1:0]           memNewIndex_o,
`ifdef ICACHE_SCHED_STATS_EN
  output logic [offsetSize-1:0]          memNewOffset_o,
  output logic [31:0]                    statFetchGrants_o,
  output logic [31:0]                    statFillGrants_o,
  output logic [31:0]                    statBubbles_o
`else
  output logic [offsetSize-1:0]          memNewOffset_o
`endif
);

  localparam int RUN_W = $clog2(FILL_BURST_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILL_BURST_MAX);

  state_t state, state_next;
  dec_t   dec;
  logic [RUN_W-1:0] fill_run, run_next;
  logic hazard, eligible, write_wanted;

  logic                           buf_valid;
  logic [cachelineSizeInBits-1:0] buf_line;
  logic [tagSize-1:0]             buf_tag;
  logic [indexSize-1:0]           buf_index;
  logic [offsetSize-1:0]          buf_offset;

  icache_fill_buffer #(
    .OFFSET_W (offsetSize),
    .INDEX_W  (indexSize),
    .TAG_W    (tagSize),
    .LINE_W   (cachelineSizeInBits)
  ) u_fill_buffer (
    .clk         (clock_i),
    .rst         (reset_i),
    .fill_valid  (fillValid_i),
    .fill_line   (fillCacheline_i),
    .fill_tag    (fillTag_i),
    .fill_index  (fillIndex_i),
    .fill_offset (fillOffset_i),
    .drain       (dec == DEC_WRITE),
    .ready       (fillReady_o),
    .buf_valid   (buf_valid),
    .buf_line    (buf_line),
    .buf_tag     (buf_tag),
    .buf_index   (buf_index),
    .buf_offset  (buf_offset)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      fill_run <= '0;
    end else begin
      state    <= state_next;
      fill_run <= run_next;
    end
  end

  // A pending write wins unless the burst budget is spent while a fetch waits.
  // When the write wants the port but a read is on the bus this cycle, the port
  // idles for one turnaround cycle instead of slipping in another read; this
  // keeps a continuous fetch stream from starving the fill.
  always_comb begin
    hazard       = buf_valid && (fetchIndex_i == buf_index);
    eligible     = fetchValid_i && !hazard;
    write_wanted = buf_valid && ((fill_run < RUN_MAX) || !eligible);
    dec          = DEC_NONE;
    state_next   = S_IDLE;
    run_next     = '0;
    if (write_wanted) begin
      if (state != S_READ) dec = DEC_WRITE;
    end else if (eligible) begin
      dec = DEC_READ;
    end
    case (dec)
      DEC_WRITE: begin
        state_next = S_WRITE;
        run_next   = (eligible && fill_run != RUN_MAX) ? fill_run + RUN_W'(1) : fill_run;
      end
      DEC_READ:  state_next = S_READ;
      default:   state_next = S_IDLE;
    endcase
  end

  // Grant is suppressed while reset is held so nothing is accepted then.
  assign fetchReady_o = (dec == DEC_READ) && !reset_i;

  // Unused bus of each cycle is forced to zero.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      memFetchEnable_o  <= 1'b0;
      memTag_o          <= '0;
      memIndex_o        <= '0;
      memOffset_o       <= '0;
      memUpdateEnable_o <= 1'b0;
      memNewCacheline_o <= '0;
      memNewTag_o       <= '0;
      memNewIndex_o     <= '0;
      memNewOffset_o    <= '0;
    end else begin
      memFetchEnable_o  <= (dec == DEC_READ);
      memTag_o          <= (dec == DEC_READ)  ? fetchTag_i    : '0;
      memIndex_o        <= (dec == DEC_READ)  ? fetchIndex_i  : '0;
      memOffset_o       <= (dec == DEC_READ)  ? fetchOffset_i : '0;
      memUpdateEnable_o <= (dec == DEC_WRITE);
      memNewCacheline_o <= (dec == DEC_WRITE) ? buf_line      : '0;
      memNewTag_o       <= (dec == DEC_WRITE) ? buf_tag       : '0;
      memNewIndex_o     <= (dec == DEC_WRITE) ? buf_index     : '0;
      memNewOffset_o    <= (dec == DEC_WRITE) ? buf_offset    : '0;
    end
  end

`ifdef ICACHE_SCHED_STATS_EN
  logic bubble;
  assign bubble = write_wanted && (state == S_READ);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      statFetchGrants_o <= '0;
      statFillGrants_o  <= '0;
      statBubbles_o     <= '0;
    end else begin
      if (dec == DEC_READ)  statFetchGrants_o <= statFetchGrants_o + 32'd1;
      if (dec == DEC_WRITE) statFillGrants_o  <= statFillGrants_o + 32'd1;
      if (bubble)           statBubbles_o     <= statBubbles_o + 32'd1;
    end
  end
`endif

endmodule
